// File: rtl/dsp_mc_unit_pkg.sv
// dsp_mc_unit_pkg: shared constants, FSM state type and a width helper
// for the multichannel FIR/level DSP unit.
//   MC_*            default geometry (channels, sample/coef width, taps)
//   CFG_*           bit positions inside cfg_reg_in
//   LEVEL_UNITY     Q1.15 gain of 1.0
//   mc_state_e      frame sequencer states
//   guard_bits()    log2 width that never collapses to zero
package dsp_mc_unit_pkg;

    localparam int MC_CHANNELS = 2;
    localparam int MC_DATA_W   = 24;
    localparam int MC_TAPS     = 8;
    localparam int MC_COEF_W   = 32;

    localparam int CFG_FILTER_EN = 0;
    localparam int CFG_MUTE      = 1;

    localparam logic [15:0] LEVEL_UNITY = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_SCALE
    } mc_state_e;

    // Counter / guard width for n items; at least one bit so a single
    // tap or channel still yields a legal vector.
    function automatic int guard_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dsp_mc_unit_if.sv
// dsp_mc_unit_if: sample/config/result bundle of the DSP unit.
//   master : drives strobes, samples, coefficients, levels, cfg word
//   slave  : the DSP unit; drives dsp_out, valid_out, busy_out, overrun_out
interface dsp_mc_unit_if
    import dsp_mc_unit_pkg::*;
#(
    parameter int CHANNELS = MC_CHANNELS,
    parameter int DATA_W   = MC_DATA_W,
    parameter int TAPS     = MC_TAPS
);
    logic                                tick_in;
    logic                                cfg_in;
    logic                                level_in;
    logic                                clr_in;
    logic [CHANNELS-1:0][DATA_W-1:0]     abuf_in;
    logic [CHANNELS*TAPS-1:0][31:0]      dsp_regs_in;
    logic [CHANNELS-1:0][15:0]           level_reg_in;
    logic [31:0]                         cfg_reg_in;
    logic [CHANNELS-1:0][DATA_W-1:0]     dsp_out;
    logic                                valid_out;
    logic                                busy_out;
    logic                                overrun_out;

    modport master (
        output tick_in, cfg_in, level_in, clr_in,
        output abuf_in, dsp_regs_in, level_reg_in, cfg_reg_in,
        input  dsp_out, valid_out, busy_out, overrun_out
    );

    modport slave (
        input  tick_in, cfg_in, level_in, clr_in,
        input  abuf_in, dsp_regs_in, level_reg_in, cfg_reg_in,
        output dsp_out, valid_out, busy_out, overrun_out
    );

endinterface

// File: rtl/dsp_mc_unit_mac.sv
// dsp_mc_unit_mac: the single shared multiplier plus accumulator.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the accumulator (wins over en)
//   en       : add smp*coef into the accumulator
//   smp      : signed sample
//   coef     : signed coefficient, one bit wider than COEF_W so +1.0 fits
//   sum      : accumulator plus the current product (combinational), used
//              by the parent to capture a channel total on its last tap
module dsp_mc_unit_mac
    import dsp_mc_unit_pkg::*;
#(
    parameter int DATA_W = MC_DATA_W,
    parameter int COEF_W = MC_COEF_W,
    parameter int ACC_W  = MC_DATA_W + MC_COEF_W + 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] smp,
    input  logic signed [COEF_W:0]   coef,
    output logic signed [ACC_W-1:0]  sum
);
    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;

    // coef magnitude never exceeds 1.0, so the product fits in PW bits.
    assign prod = PW'(smp) * PW'(coef);
    assign sum  = acc + ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/dsp_mc_unit.sv
// dsp_mc_unit: multichannel FIR + level + saturation on each sample tick.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of dsp_mc_unit_if
//     tick_in starts a frame; cfg_in/level_in load the shadow set;
//     clr_in flushes history and aborts the frame; dsp_out/valid_out carry
//     the result; busy_out spans LOAD..SCALE; overrun_out flags lost ticks.
// One multiplier is time-shared over CHANNELS*TAPS MAC cycles; the
// final scaling runs for all channels in parallel in SCALE.
module dsp_mc_unit
    import dsp_mc_unit_pkg::*;
#(
    parameter int CHANNELS = MC_CHANNELS,
    parameter int DATA_W   = MC_DATA_W,
    parameter int TAPS     = MC_TAPS,
    parameter int COEF_W   = MC_COEF_W
) (
    input  logic         clk,
    input  logic         rst,
    dsp_mc_unit_if.slave bus
);
    localparam int TW    = guard_bits(TAPS);
    localparam int CHW   = guard_bits(CHANNELS);
    localparam int ACC_W = DATA_W + COEF_W + guard_bits(TAPS);
    localparam int YW    = ACC_W - (COEF_W - 1);
    localparam int ZW    = YW + 17;

    mc_state_e state_q, state_d;

    logic [CHANNELS-1:0][TAPS-1:0][DATA_W-1:0] dline;
    logic [CHANNELS-1:0][TAPS-1:0][COEF_W-1:0] sh_coef, act_coef;
    logic [CHANNELS-1:0][15:0]                 sh_level, act_level;
    logic [1:0]                                sh_cfg, act_cfg;

    logic [TW-1:0]                  tap_cnt;
    logic [CHW-1:0]                 ch_cnt;
    logic                           last_tap, last_ch;
    logic                           do_load, mac_en, mac_clr;
    logic signed [DATA_W-1:0]       mac_smp;
    logic signed [COEF_W:0]         mac_coef;
    logic signed [ACC_W-1:0]        mac_sum;
    logic [CHANNELS-1:0][ACC_W-1:0] ch_acc;

    logic [CHANNELS-1:0][DATA_W-1:0] scaled, dsp_q;
    logic                            valid_q, ovr_q;
    logic                            cfg_unused;

    assign cfg_unused = ^bus.cfg_reg_in[31:2];

    assign last_tap = (tap_cnt == TW'(TAPS - 1));
    assign last_ch  = (ch_cnt == CHW'(CHANNELS - 1));

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (bus.tick_in) state_d = ST_LOAD;
            ST_LOAD: begin
                do_load = 1'b1;
                mac_clr = 1'b1;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                mac_en = 1'b1;
                // channel total is captured from mac_sum this cycle, so the
                // accumulator can restart for the next channel.
                if (last_tap) begin
                    mac_clr = 1'b1;
                    if (last_ch) state_d = ST_SCALE;
                end
            end
            ST_SCALE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // clear beats everything, including a tick seen in IDLE
        if (bus.clr_in) begin
            state_d = ST_IDLE;
            do_load = 1'b0;
            mac_en  = 1'b0;
            mac_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || do_load) begin
            tap_cnt <= '0;
            ch_cnt  <= '0;
        end else if (mac_en) begin
            if (last_tap) begin
                tap_cnt <= '0;
                ch_cnt  <= ch_cnt + 1'b1;
            end else begin
                tap_cnt <= tap_cnt + 1'b1;
            end
        end
    end

    // ---------------- delay lines ----------------
    always_ff @(posedge clk) begin
        if (rst || bus.clr_in) begin
            dline <= '0;
        end else if (do_load) begin
            for (int c = 0; c < CHANNELS; c++) begin
                dline[c][0] <= bus.abuf_in[c];
                for (int k = 1; k < TAPS; k++)
                    dline[c][k] <= dline[c][k-1];
            end
        end
    end

    // ---------------- shadow and active sets ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_cfg   <= '0;
            sh_coef  <= '0;
            sh_level <= {CHANNELS{LEVEL_UNITY}};
        end else begin
            if (bus.cfg_in) begin
                sh_cfg <= bus.cfg_reg_in[CFG_MUTE:CFG_FILTER_EN];
                for (int c = 0; c < CHANNELS; c++)
                    for (int k = 0; k < TAPS; k++)
                        sh_coef[c][k] <= bus.dsp_regs_in[c*TAPS+k][COEF_W-1:0];
            end
            if (bus.level_in)
                sh_level <= bus.level_reg_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_cfg   <= '0;
            act_coef  <= '0;
            act_level <= {CHANNELS{LEVEL_UNITY}};
        end else if (do_load) begin
            act_cfg   <= sh_cfg;
            act_coef  <= sh_coef;
            act_level <= sh_level;
        end
    end

    // ---------------- MAC datapath ----------------
    assign mac_smp = dline[ch_cnt][tap_cnt];

    // Bypass feeds exactly +1.0 on tap 0, which needs the extra coef bit.
    always_comb begin
        if (act_cfg[CFG_FILTER_EN])
            mac_coef = {act_coef[ch_cnt][tap_cnt][COEF_W-1], act_coef[ch_cnt][tap_cnt]};
        else if (tap_cnt == '0)
            mac_coef = {2'b01, {(COEF_W-1){1'b0}}};
        else
            mac_coef = '0;
    end

    dsp_mc_unit_mac #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .smp (mac_smp),
        .coef(mac_coef),
        .sum (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst)
            ch_acc <= '0;
        else if (mac_en && last_tap)
            ch_acc[ch_cnt] <= mac_sum;
    end

    // ---------------- per-channel scale / saturate ----------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_scale
        logic signed [YW-1:0] y;
        logic signed [ZW-1:0] zp, z;
        logic                 fits;
        logic [DATA_W-1:0]    sat;

        // >>> on a signed value floors toward -inf
        assign y    = YW'($signed(ch_acc[c]) >>> (COEF_W - 1));
        assign zp   = ZW'(y) * ZW'($signed({1'b0, act_level[c]}));
        assign z    = zp >>> 15;
        // in range when every bit above the DATA_W sign bit copies it
        assign fits = (&z[ZW-1:DATA_W-1]) | ~(|z[ZW-1:DATA_W-1]);
        assign sat  = fits     ? z[DATA_W-1:0] :
                      z[ZW-1]  ? {1'b1, {(DATA_W-1){1'b0}}} :
                                 {1'b0, {(DATA_W-1){1'b1}}};
        assign scaled[c] = act_cfg[CFG_MUTE] ? '0 : sat;
    end

    // ---------------- outputs ----------------
    always_ff @(posedge clk) begin
        if (rst || bus.clr_in)
            dsp_q <= '0;
        else if (state_q == ST_SCALE)
            dsp_q <= scaled;
    end

    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= 1'b0;
        else
            valid_q <= (state_q == ST_SCALE) && !bus.clr_in;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr_in)
            ovr_q <= 1'b0;
        else if (bus.tick_in && state_q != ST_IDLE)
            ovr_q <= 1'b1;
    end

    assign bus.dsp_out     = dsp_q;
    assign bus.valid_out   = valid_q;
    assign bus.busy_out    = (state_q != ST_IDLE);
    assign bus.overrun_out = ovr_q;

endmodule

// File: tb/tb_dsp_mc_unit.sv
// Self-checking bench for dsp_mc_unit with CHANNELS=2, TAPS=4.
// Reference model: per-channel sample history and shadow/active settings,
// frame output computed with plain 64-bit arithmetic.
module tb_dsp_mc_unit;
    import dsp_mc_unit_pkg::*;

    localparam int CH  = 2;
    localparam int DW  = 24;
    localparam int T   = 4;
    localparam int CW  = 32;
    localparam int LAT = CH*T + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_mc_unit_if #(.CHANNELS(CH), .DATA_W(DW), .TAPS(T)) bus();

    dsp_mc_unit #(.CHANNELS(CH), .DATA_W(DW), .TAPS(T), .COEF_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    longint  hist[CH][T];
    longint  sh_coef[CH][T], act_coef[CH][T], new_coef[CH][T];
    longint  sh_level[CH], act_level[CH];
    bit      sh_fen, sh_mute, act_fen, act_mute;
    logic [DW-1:0] exp_out[CH];

    function automatic longint sext(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < T; k++) begin
                hist[c][k] = 0; sh_coef[c][k] = 0; act_coef[c][k] = 0;
            end
            sh_level[c] = 32768; act_level[c] = 32768;
        end
        sh_fen = 0; sh_mute = 0; act_fen = 0; act_mute = 0;
    endtask

    // accepted tick: push samples, snapshot settings, compute the frame
    task automatic model_frame();
        longint acc, y, z, cf;
        longint maxv = (longint'(1) << (DW-1)) - 1;
        longint minv = -(longint'(1) << (DW-1));
        act_fen = sh_fen; act_mute = sh_mute;
        for (int c = 0; c < CH; c++) begin
            for (int k = T-1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = sext(bus.abuf_in[c]);
            act_level[c] = sh_level[c];
            for (int k = 0; k < T; k++) act_coef[c][k] = sh_coef[c][k];
            acc = 0;
            for (int k = 0; k < T; k++) begin
                if (act_fen) cf = act_coef[c][k];
                else         cf = (k == 0) ? (longint'(1) << (CW-1)) : 0;
                acc += hist[c][k] * cf;
            end
            y = acc >>> (CW-1);
            z = (y * act_level[c]) >>> 15;
            if (z > maxv) z = maxv;
            if (z < minv) z = minv;
            if (act_mute) z = 0;
            exp_out[c] = z[DW-1:0];
        end
    endtask

    // ---------------- drivers (enter and leave on a falling edge) ----------
    task automatic write_regs(input bit do_cfg, input bit do_lvl, input bit fen,
                              input bit mute, input logic [15:0] l0, input logic [15:0] l1);
        logic [31:0] w;
        w = $urandom();
        w[CFG_FILTER_EN] = fen;
        w[CFG_MUTE]      = mute;
        bus.cfg_reg_in = w;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < T; k++)
                bus.dsp_regs_in[c*T+k] = new_coef[c][k][31:0];
        bus.level_reg_in[0] = l0;
        bus.level_reg_in[1] = l1;
        bus.cfg_in   = do_cfg;
        bus.level_in = do_lvl;
        @(negedge clk);
        bus.cfg_in   = 1'b0;
        bus.level_in = 1'b0;
        if (do_cfg) begin
            sh_fen = fen; sh_mute = mute;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < T; k++) sh_coef[c][k] = new_coef[c][k];
        end
        if (do_lvl) begin
            sh_level[0] = longint'(l0); sh_level[1] = longint'(l1);
        end
    endtask

    task automatic pulse_clr();
        bus.clr_in = 1'b1;
        @(negedge clk);
        bus.clr_in = 1'b0;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < T; k++) hist[c][k] = 0;
    endtask

    // tick driven in cycle t; returns at the start of cycle t+1
    task automatic issue_tick(input logic [DW-1:0] a0, input logic [DW-1:0] a1);
        bus.abuf_in[0] = a0;
        bus.abuf_in[1] = a1;
        bus.tick_in = 1'b1;
        model_frame();
        @(negedge clk);
        bus.tick_in = 1'b0;
    endtask

    // current cycle index = start; lat = cycle where valid_out is seen, -1 on timeout
    task automatic wait_valid(input int start, output int lat);
        lat = -1;
        for (int n = start + 1; n <= start + 40 && lat < 0; n++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) lat = n;
        end
    endtask

    function automatic logic [DW-1:0] rnd_smp();
        logic [DW-1:0] s;
        case ($urandom_range(0, 5))
            0:       s = 24'h7FFFFF;
            1:       s = 24'h800000;
            default: s = DW'($urandom());
        endcase
        return s;
    endfunction

    task automatic clear_new_coef();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < T; k++) new_coef[c][k] = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++; if (bus.dsp_out !== '0) begin errors++; $display("FAIL reset_dsp_out got %h exp 0", bus.dsp_out); end
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid_out); end
        checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_out); end
        checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun_out); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] keep0, keep1;
        issue_tick(24'h100000, 24'hF00000);
        checks++; if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL bypass_busy cyc 1 got %b exp 1", bus.busy_out); end
        for (int i = 2; i <= LAT + 1; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy_out !== (i <= LAT-1)) begin errors++; $display("FAIL bypass_busy cyc %0d got %b exp %b", i, bus.busy_out, (i <= LAT-1)); end
            checks++;
            if (bus.valid_out !== (i == LAT)) begin errors++; $display("FAIL bypass_valid cyc %0d got %b exp %b", i, bus.valid_out, (i == LAT)); end
            if (i == LAT) begin
                keep0 = bus.dsp_out[0]; keep1 = bus.dsp_out[1];
                checks++; if (keep0 !== 24'h100000) begin errors++; $display("FAIL bypass_L got %h exp 100000", keep0); end
                checks++; if (keep1 !== 24'hF00000) begin errors++; $display("FAIL bypass_R got %h exp f00000", keep1); end
                checks++; if (keep0 !== exp_out[0] || keep1 !== exp_out[1]) begin errors++; $display("FAIL bypass_model got %h %h exp %h %h", keep0, keep1, exp_out[0], exp_out[1]); end
            end
        end
        checks++; if (bus.dsp_out[0] !== 24'h100000) begin errors++; $display("FAIL bypass_hold got %h exp 100000", bus.dsp_out[0]); end
    endtask

    task automatic test_filter();
        logic [DW-1:0] exp_l[3];
        logic [DW-1:0] in_l[3];
        int lat;
        exp_l[0] = 24'h100000; exp_l[1] = 24'h100000; exp_l[2] = 24'h000000;
        in_l[0] = 24'h200000;  in_l[1] = 24'h0;       in_l[2] = 24'h0;
        clear_new_coef();
        for (int c = 0; c < CH; c++) begin new_coef[c][0] = 64'h40000000; new_coef[c][1] = 64'h40000000; end
        write_regs(1, 0, 1, 0, 16'h0, 16'h0);
        pulse_clr();
        for (int f = 0; f < 3; f++) begin
            issue_tick(in_l[f], (f == 0) ? 24'hE00000 : 24'h0);
            wait_valid(1, lat);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL filter_latency f%0d got %0d exp %0d", f, lat, LAT); end
            checks++; if (bus.dsp_out[0] !== exp_l[f]) begin errors++; $display("FAIL filter_L f%0d got %h exp %h", f, bus.dsp_out[0], exp_l[f]); end
            checks++; if (bus.dsp_out[1] !== exp_out[1]) begin errors++; $display("FAIL filter_R f%0d got %h exp %h", f, bus.dsp_out[1], exp_out[1]); end
        end
        checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL filter_b2b_overrun got %b exp 0", bus.overrun_out); end
    endtask

    task automatic test_saturation();
        int lat;
        clear_new_coef();
        write_regs(1, 1, 0, 0, 16'hFFFF, 16'hFFFF);
        issue_tick(24'h7FFFFF, 24'h800000);
        wait_valid(1, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL sat_latency got %0d exp %0d", lat, LAT); end
        checks++; if (bus.dsp_out[0] !== 24'h7FFFFF) begin errors++; $display("FAIL sat_pos got %h exp 7fffff", bus.dsp_out[0]); end
        checks++; if (bus.dsp_out[1] !== 24'h800000) begin errors++; $display("FAIL sat_neg got %h exp 800000", bus.dsp_out[1]); end
        // half gain on odd values: floor rounding of the level product
        write_regs(0, 1, 0, 0, 16'h4000, 16'h4000);
        issue_tick(24'hFFFFFD, 24'h000003);
        wait_valid(1, lat);
        checks++; if (bus.dsp_out[0] !== 24'hFFFFFE) begin errors++; $display("FAIL floor_neg got %h exp fffffe", bus.dsp_out[0]); end
        checks++; if (bus.dsp_out[1] !== 24'h000001) begin errors++; $display("FAIL floor_pos got %h exp 000001", bus.dsp_out[1]); end
    endtask

    task automatic test_overrun_shadow();
        int lat, nval;
        write_regs(1, 1, 0, 0, 16'h8000, 16'h8000);
        issue_tick(24'h123456, 24'hABCDEF);           // now cycle 1
        repeat (2) @(negedge clk);                     // cycle 3
        write_regs(1, 0, 0, 1, 16'h0, 16'h0);          // mute into shadow, now cycle 4
        @(negedge clk);                                // cycle 5
        bus.tick_in = 1'b1;
        @(negedge clk);                                // cycle 6
        bus.tick_in = 1'b0;
        checks++; if (bus.overrun_out !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", bus.overrun_out); end
        wait_valid(6, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL shadow_latency got %0d exp %0d", lat, LAT); end
        checks++; if (bus.dsp_out[0] !== 24'h123456 || bus.dsp_out[1] !== 24'hABCDEF) begin errors++; $display("FAIL shadow_unmuted got %h %h exp 123456 abcdef", bus.dsp_out[0], bus.dsp_out[1]); end
        nval = 0;
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (bus.valid_out === 1'b1) nval++; end
        checks++; if (nval !== 0) begin errors++; $display("FAIL dropped_tick_frame got %0d valids exp 0", nval); end
        issue_tick(24'h234567, 24'h765432);
        wait_valid(1, lat);
        checks++; if (bus.dsp_out !== '0 || exp_out[0] !== '0) begin errors++; $display("FAIL muted_frame got %h exp 0 (model %h)", bus.dsp_out, exp_out[0]); end
        checks++; if (bus.overrun_out !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", bus.overrun_out); end
        pulse_clr();
        checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL overrun_clr got %b exp 0", bus.overrun_out); end
    endtask

    task automatic test_clear();
        int lat, nval;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < T; k++) new_coef[c][k] = longint'($signed($urandom()));
        write_regs(1, 1, 1, 0, 16'h8000, 16'h6000);
        for (int f = 0; f < 2; f++) begin
            issue_tick(rnd_smp(), rnd_smp());
            wait_valid(1, lat);
            checks++; if (bus.dsp_out[0] !== exp_out[0] || bus.dsp_out[1] !== exp_out[1]) begin errors++; $display("FAIL clr_pre f%0d got %h %h exp %h %h", f, bus.dsp_out[0], bus.dsp_out[1], exp_out[0], exp_out[1]); end
        end
        issue_tick(rnd_smp(), rnd_smp());              // cycle 1
        repeat (5) @(negedge clk);                     // cycle 6
        pulse_clr();                                   // cycle 7
        checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL clr_idle got busy %b exp 0", bus.busy_out); end
        checks++; if (bus.dsp_out !== '0) begin errors++; $display("FAIL clr_dsp_out got %h exp 0", bus.dsp_out); end
        nval = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (bus.valid_out === 1'b1) nval++; end
        checks++; if (nval !== 0) begin errors++; $display("FAIL clr_no_valid got %0d exp 0", nval); end
        for (int f = 0; f < T; f++) begin
            issue_tick((f == 0) ? 24'h300000 : 24'h0, (f == 0) ? 24'hC00000 : 24'h0);
            wait_valid(1, lat);
            checks++; if (bus.dsp_out[0] !== exp_out[0] || bus.dsp_out[1] !== exp_out[1]) begin errors++; $display("FAIL clr_impulse f%0d got %h %h exp %h %h", f, bus.dsp_out[0], bus.dsp_out[1], exp_out[0], exp_out[1]); end
        end
    endtask

    task automatic test_random();
        int lat, start;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int c = 0; c < CH; c++)
                    for (int k = 0; k < T; k++) new_coef[c][k] = longint'($signed($urandom()));
                write_regs(1, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                           $urandom_range(0, 7) == 0, 16'($urandom()), 16'($urandom()));
            end
            issue_tick(rnd_smp(), rnd_smp());
            start = 1;
            // shadow write mid-frame must not touch this frame
            if ($urandom_range(0, 3) == 0) begin
                for (int c = 0; c < CH; c++)
                    for (int k = 0; k < T; k++) new_coef[c][k] = longint'($signed($urandom()));
                write_regs(1, 1, $urandom_range(0, 1), $urandom_range(0, 7) == 0,
                           16'($urandom()), 16'($urandom()));
                start = 2;
            end
            wait_valid(start, lat);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency f%0d got %0d exp %0d", f, lat, LAT); end
            checks++; if (bus.dsp_out[0] !== exp_out[0] || bus.dsp_out[1] !== exp_out[1]) begin errors++; $display("FAIL rand_out f%0d got %h %h exp %h %h", f, bus.dsp_out[0], bus.dsp_out[1], exp_out[0], exp_out[1]); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL rand_overrun got %b exp 0", bus.overrun_out); end
    endtask

    initial begin
        rst = 1'b1;
        bus.tick_in = 1'b0; bus.cfg_in = 1'b0; bus.level_in = 1'b0; bus.clr_in = 1'b0;
        bus.abuf_in = '0; bus.dsp_regs_in = '0; bus.level_reg_in = '0; bus.cfg_reg_in = '0;
        clear_new_coef();
        model_reset();
        test_reset();
        test_bypass();
        test_filter();
        test_saturation();
        test_overrun_shadow();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
